// File: rtl/gate_truth_scanner_if.sv
// Handshake and gate-block bus for gate_truth_scanner.
// err_count exists only when GATE_SCAN_ERRCNT_EN is defined.
interface gate_truth_scanner_if;
    logic        start;
    logic        a_out;
    logic        b_out;
    logic [7:0]  gate_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  fail_mask;
    logic [31:0] capture;
`ifdef GATE_SCAN_ERRCNT_EN
    logic [7:0]  err_count;

    modport slave (
        input  start, gate_in,
        output a_out, b_out, busy, done, pass,
        output fail_mask, capture, err_count
    );

    modport master (
        output start, gate_in,
        input  a_out, b_out, busy, done, pass,
        input  fail_mask, capture, err_count
    );
`else
    modport slave (
        input  start, gate_in,
        output a_out, b_out, busy, done, pass,
        output fail_mask, capture
    );

    modport master (
        output start, gate_in,
        input  a_out, b_out, busy, done, pass,
        input  fail_mask, capture
    );
`endif
endinterface

// File: rtl/gate_truth_scanner.sv
// Walks the gate block through all four a/b vectors, captures and checks
// the outputs. Optional GATE_SCAN_ERRCNT_EN adds a mismatch-cycle counter.
module gate_truth_scanner #(
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gate_truth_scanner_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST =
        4'((SETTLE == 0) ? 0 : SETTLE - 1);

    localparam logic [1:0] S_AFTER_VEC =
        (SETTLE == 0) ? S_SAMPLE : S_WAIT;

    logic [1:0]  state;
    logic [1:0]  vec;
    logic [3:0]  cnt;
    logic        a_q;
    logic        b_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [7:0]  fail_q;
    logic [31:0] cap_q;
    logic [1:0]  vec_nxt;
    logic [7:0]  exp_byte;
    logic [7:0]  diff;
    logic        go;

    // Expected truth-table byte for the vector currently driven.
    always_comb begin
        logic a;
        logic b;
        a        = vec[1];
        b        = vec[0];
        exp_byte = {~(a ^ b), a ^ b, ~(a | b), ~(a & b),
                    a, ~a, a | b, a & b};
        diff     = bus.gate_in ^ exp_byte;
        vec_nxt  = vec + 2'd1;
        go       = (state == S_IDLE) && bus.start;
    end

    // Sequencer: vector stepping, settle wait and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            vec    <= 2'd0;
            cnt    <= 4'd0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        vec    <= 2'd0;
                        cnt    <= 4'd0;
                        a_q    <= 1'b0;
                        b_q    <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= S_AFTER_VEC;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= 4'd0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (vec == 2'd3) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        vec   <= vec_nxt;
                        a_q   <= vec_nxt[1];
                        b_q   <= vec_nxt[0];
                        state <= S_AFTER_VEC;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers: capture bytes, sticky mismatches and verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q  <= 32'd0;
            fail_q <= 8'd0;
            pass_q <= 1'b0;
        end else if (go) begin
            cap_q  <= 32'd0;
            fail_q <= 8'd0;
            pass_q <= 1'b0;
        end else if (state == S_SAMPLE) begin
            cap_q[{vec, 3'b000} +: 8] <= bus.gate_in;
            fail_q <= fail_q | diff;
            if (vec == 2'd3) begin
                pass_q <= ((fail_q | diff) == 8'd0);
            end
        end
    end

`ifdef GATE_SCAN_ERRCNT_EN
    logic [7:0] err_q;

    // Saturating count of sampled vectors showing any mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (go) begin
            err_q <= 8'd0;
        end else if (state == S_SAMPLE && diff != 8'd0
                     && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.err_count = err_q;
`endif

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
    assign bus.capture   = cap_q;

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Bench for gate_truth_scanner: SETTLE=1 and SETTLE=0 instances driven
// by a modelled gate block with injectable stuck-at faults.
module tb_gate_truth_scanner;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] s0;
    logic [7:0] s1;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gate_truth_scanner_if b1 ();
    gate_truth_scanner_if b0 ();

    gate_truth_scanner #(.SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    gate_truth_scanner #(.SETTLE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    // Behavioural gate block, one gate per bit.
    function automatic logic [7:0] gate_block(input logic a,
                                              input logic b);
        logic [7:0] g;
        g[0] = a & b;
        g[1] = a | b;
        g[2] = !a;
        g[3] = a;
        g[4] = !(a & b);
        g[5] = !(a | b);
        g[6] = (a != b);
        g[7] = (a == b);
        return g;
    endfunction

    assign b1.gate_in = (gate_block(b1.a_out, b1.b_out) & ~s0) | s1;
    assign b0.gate_in = gate_block(b0.a_out, b0.b_out);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results from the published truth-table bytes.
    task automatic model(input logic [7:0] f0, input logic [7:0] f1,
                         output logic [31:0] cap,
                         output logic [7:0] fm, output int ne);
        logic [7:0] tt [4];
        logic [7:0] c;
        logic [7:0] d;
        tt = '{8'hB4, 8'h56, 8'h5A, 8'h8B};
        cap = 32'd0;
        fm = 8'd0;
        ne = 0;
        for (int v = 0; v < 4; v++) begin
            c = (tt[v] & ~f0) | f1;
            cap[8*v +: 8] = c;
            d = c ^ tt[v];
            fm = fm | d;
            if (d != 8'd0 && ne < 255) ne++;
        end
    endtask

    task automatic check_results(input string tag,
                                 input logic [7:0] f0,
                                 input logic [7:0] f1);
        logic [31:0] cap;
        logic [7:0] fm;
        int ne;
        model(f0, f1, cap, fm, ne);
        check({tag, "_capture"}, b1.capture, cap);
        check({tag, "_fail"}, 32'(b1.fail_mask), 32'(fm));
        check({tag, "_pass"}, 32'(b1.pass), 32'(fm == 8'd0));
`ifdef GATE_SCAN_ERRCNT_EN
        check({tag, "_errcnt"}, 32'(b1.err_count), 32'(ne));
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ab"}, 32'({b1.a_out, b1.b_out}), 32'd0);
        check({tag, "_busy"}, 32'(b1.busy), 32'd0);
        check({tag, "_done"}, 32'(b1.done), 32'd0);
        check({tag, "_pass"}, 32'(b1.pass), 32'd0);
        check({tag, "_fail"}, 32'(b1.fail_mask), 32'd0);
        check({tag, "_capture"}, b1.capture, 32'd0);
`ifdef GATE_SCAN_ERRCNT_EN
        check({tag, "_errcnt"}, 32'(b1.err_count), 32'd0);
`endif
    endtask

    // One SETTLE=1 scan; optional stray start pulse in cycle k+pulse.
    task automatic scan1(input string tag, input logic [7:0] f0,
                         input logic [7:0] f1, input int pulse);
        int first_done;
        int ndone;
        s0 = f0;
        s1 = f1;
        first_done = 0;
        ndone = 0;
        @(negedge clk);
        b1.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            b1.start = (n == pulse);
            if (n < 9) begin
                check({tag, "_ab"}, 32'({b1.a_out, b1.b_out}),
                      32'((n - 1) / 2));
                check({tag, "_busy"}, 32'(b1.busy), 32'd1);
            end
            if (n == 9) check({tag, "_busy_end"}, 32'(b1.busy), 32'd0);
            if (b1.done) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
        end
        check({tag, "_done_cycle"}, 32'(first_done), 32'd9);
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check_results(tag, f0, f1);
    endtask

    initial begin
        int ndone;
        logic [7:0] r0;
        logic [7:0] r1;
        rst = 1'b1;
        b1.start = 1'b0;
        b0.start = 1'b0;
        s0 = 8'd0;
        s1 = 8'd0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        scan1("good", 8'h00, 8'h00, 0);
        check("good_const", b1.capture, 32'h8B5A56B4);

        scan1("xor_stuck0", 8'h40, 8'h00, 0);
        check("xor_const", b1.capture, 32'h8B1A16B4);
        check("xor_fail_const", 32'(b1.fail_mask), 32'h40);

        for (int i = 0; i < 6; i++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom) & 8'($urandom) & ~r0;
            scan1("rand", r0, r1, 0);
        end

        scan1("stray_start", 8'h00, 8'h00, 3);

        // reset beats a coincident start
        @(negedge clk);
        rst = 1'b1;
        b1.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b1.start = 1'b0;
        check_reset("rst_start");

        // reset in the middle of a faulty scan
        s0 = 8'h10;
        @(negedge clk);
        b1.start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            b1.start = 1'b0;
            if (n == 5) begin
                rst = 1'b0;
                check_reset("mid_rst");
            end
            if (n == 4) rst = 1'b1;
            if (b1.done) ndone++;
        end
        check("mid_rst_no_done", 32'(ndone), 32'd0);
        scan1("after_rst", 8'h00, 8'h00, 0);

        // back-to-back with start held; fault only in first scan
        s0 = 8'h01;
        @(negedge clk);
        b1.start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (b1.done) ndone++;
            if (n == 9) begin
                check("b2b_done1", 32'(b1.done), 32'd1);
                check_results("b2b_first", 8'h01, 8'h00);
                s0 = 8'h00;
            end
            if (n == 11) begin
                check("b2b_busy2", 32'(b1.busy), 32'd1);
                check("b2b_fail_clr", 32'(b1.fail_mask), 32'd0);
            end
            if (n == 19) begin
                check("b2b_done2", 32'(b1.done), 32'd1);
                check_results("b2b_second", 8'h00, 8'h00);
                b1.start = 1'b0;
            end
        end
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_idle", 32'(b1.busy), 32'd0);

        // SETTLE=0 instance: one vector per cycle
        @(negedge clk);
        b0.start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            b0.start = 1'b0;
            if (n <= 4) begin
                check("s0_ab", 32'({b0.a_out, b0.b_out}), 32'(n - 1));
            end
            if (n == 5) check("s0_done", 32'(b0.done), 32'd1);
            if (b0.done) ndone++;
        end
        check("s0_done_count", 32'(ndone), 32'd1);
        check("s0_capture", b0.capture, 32'h8B5A56B4);
        check("s0_fail", 32'(b0.fail_mask), 32'd0);
        check("s0_pass", 32'(b0.pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
